// File: rtl/data_sram_responder.sv
// Data-SRAM responder for the CPU data port.
// Byte-enabled writes, full-word reads with configurable latency and stall.
module data_sram_responder #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stallreq
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
      $error("data_sram_responder: RD_LAT must be 1..15");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_q, idx_nxt;
  logic [ADDR_W-1:0] rd_idx;
  logic              stall_nxt;
  logic              rd_load;
  logic              wr_go;
  logic [31:0]       mem [DEPTH];

  // Low bits select a byte lane, high bits alias; neither reaches the array.
  logic addr_unused;
  assign addr_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign idx = addr[ADDR_W+1:2];

  // Next-state, counter and read/write strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    stall_nxt = stallreq;
    rd_load   = 1'b0;
    wr_go     = 1'b0;
    rd_idx    = idx_q;
    unique case (state)
      IDLE: begin
        if (en) begin
          if (wen != 4'b0000) begin
            wr_go = 1'b1;
          end else if (RD_LAT == 1) begin
            rd_load = 1'b1;
            rd_idx  = idx;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(RD_LAT - 1);
            idx_nxt   = idx;
            stall_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          rd_load   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
          stall_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter, latched index, stall flag and read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= 4'd0;
      idx_q    <= '0;
      stallreq <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      cnt      <= cnt_nxt;
      idx_q    <= idx_nxt;
      stallreq <= stall_nxt;
      if (rd_load) begin
        rdata <= mem[rd_idx];
      end
    end
  end

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
